// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd
// Function : Sequential double-dabble converter, binary to 4 BCD digits.
//            Define BCD_OVERFLOW_EN to flag inputs >= 10000 (digits E, ovf=1).
// Revision : 1.0
// ============================================================================
module bin_to_bcd #(
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [3:0]        num1,
    output logic [3:0]        num2,
    output logic [3:0]        num3,
    output logic [3:0]        num4
`ifdef BCD_OVERFLOW_EN
    ,
    output logic              ovf
`endif
);

    localparam int ACC_W = 20;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       num_q, num_d;
    logic              done_q, done_d;
`ifdef BCD_OVERFLOW_EN
    logic              ovf_q, ovf_d;
`endif

    // Per-nibble add-3 correction applied before every shift.
    logic [ACC_W-1:0]  acc_adj;
    for (genvar i = 0; i < ACC_W / 4; i++) begin : g_adj
        assign acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                            : acc_q[4*i +: 4];
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        done_d  = 1'b0;
`ifdef BCD_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Accumulator and shift register act as one wide register.
                acc_d = ACC_W'({acc_adj, sr_q[DATA_W-1]});
                sr_d  = sr_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef BCD_OVERFLOW_EN
                if (acc_q[19:16] != 4'd0) begin
                    num_d = 16'hEEEE;
                    ovf_d = 1'b1;
                end else begin
                    num_d = acc_q[15:0];
                    ovf_d = 1'b0;
                end
`else
                num_d = acc_q[15:0];
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            done_q  <= 1'b0;
`ifdef BCD_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            done_q  <= done_d;
`ifdef BCD_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign num1 = num_q[15:12];
    assign num2 = num_q[11:8];
    assign num3 = num_q[7:4];
    assign num4 = num_q[3:0];
`ifdef BCD_OVERFLOW_EN
    assign ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd.sv
`default_nettype none
// Testbench for bin_to_bcd: random and directed conversions, scoreboard checked.
module tb_bin_to_bcd;

    localparam int DATA_W = 14;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] bin;
    logic              busy;
    logic              done;
    logic [3:0]        num1, num2, num3, num4;
`ifdef BCD_OVERFLOW_EN
    logic              ovf;
`endif

    bin_to_bcd #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .num1  (num1),
        .num2  (num2),
        .num3  (num3),
        .num4  (num4)
`ifdef BCD_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #20 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;

    // Reference: decimal digits by plain arithmetic, {ovf, d1, d2, d3, d4}.
    function automatic logic [16:0] ref_model(input int unsigned v);
        int unsigned m;
`ifdef BCD_OVERFLOW_EN
        if (v >= 10000) return {1'b1, 16'hEEEE};
`endif
        m = v % 10000;
        return {1'b0, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("digits", int'({num1, num2, num3, num4}), int'(mon_e[15:0]));
`ifdef BCD_OVERFLOW_EN
                chk("ovf", int'(ovf), int'(mon_e[16]));
`endif
            end
        end
    end

    task automatic run_conv(input int unsigned v, input bit intrude);
        int lat;
        int nbusy;
        bit stable;
        logic [15:0] held;
        @(negedge clk);
        start = 1'b1;
        bin   = DATA_W'(v);
        exp_q.push_back(ref_model(v));
        held  = {num1, num2, num3, num4};
        @(negedge clk);
        start  = 1'b0;
        bin    = DATA_W'($urandom);
        lat    = 0;
        nbusy  = 0;
        stable = 1'b1;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            if ({num1, num2, num3, num4} !== held) stable = 1'b0;
            if (intrude && lat == 5) begin
                start = 1'b1;
                bin   = DATA_W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, DATA_W + 1);
        chk("busy_cycles", nbusy, DATA_W + 1);
        chk("busy_low_at_done", int'(busy), 0);
        chk("digits_held", int'(stable), 1);
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_digits", int'({num1, num2, num3, num4}), 0);
`ifdef BCD_OVERFLOW_EN
        chk("reset_ovf", int'(ovf), 0);
`endif
        reset = 1'b0;

        run_conv(1234, 1'b0);
        run_conv(9999, 1'b0);
        run_conv(0, 1'b0);
        run_conv(5, 1'b0);
        run_conv(42, 1'b1);

        // Abort a conversion mid-shift with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        bin   = DATA_W'(8765);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #5 reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_digits", int'({num1, num2, num3, num4}), 0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("no_done_after_abort", seen, 0);
        run_conv(321, 1'b0);

        run_conv(12345, 1'b0);
        run_conv(16383, 1'b0);
        run_conv(10000, 1'b0);
        run_conv(9990, 1'b0);

        // start held high: a second conversion launches right after DONE.
        @(negedge clk);
        start = 1'b1;
        bin   = DATA_W'(777);
        exp_q.push_back(ref_model(777));
        exp_q.push_back(ref_model(4096));
        @(negedge clk);
        bin = DATA_W'(4096);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("held_first_latency", lat, DATA_W + 1);
        @(negedge clk);
        start = 1'b0;
        bin   = DATA_W'($urandom);
        lat   = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("held_relaunch_latency", lat, DATA_W + 1);

        for (int i = 0; i < 20; i++) begin
            run_conv($urandom_range(0, (1 << DATA_W) - 1), 1'b0);
        end

        repeat (40) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter: DATA_W, default 14, width of binary input value.
REQ-002 clk  input  1  system clock, 25 MHz; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; clears all state immediately on assertion.
REQ-004 start  input  1  request pulse; samples bin when block is idle.
REQ-005 bin  input  DATA_W  unsigned binary value to convert.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when new digits are presented.
REQ-008 num1  output  4  thousands digit (leftmost display position).
REQ-009 num2  output  4  hundreds digit.
REQ-010 num3  output  4  tens digit.
REQ-011 num4  output  4  units digit (rightmost display position).

Function
REQ-012 Block SHALL convert bin to four BCD digits by sequential shift-and-add-3 (double dabble), one input bit per clock, MSB first.
REQ-013 State machine SHALL have states IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 IDLE: start=1 at a rising edge SHALL load bin into a shift register, clear the BCD accumulator and bit counter, and move to SHIFT.
REQ-015 SHIFT: each clock, every BCD nibble >= 5 SHALL have 3 added, then accumulator and shift register SHALL shift left by one as a single combined register.
REQ-016 SHIFT SHALL last exactly DATA_W clocks, then move to DONE.
REQ-017 DONE: num1..num4 SHALL update from the accumulator, done SHALL be high for exactly this one cycle, and the next state SHALL be IDLE.
REQ-018 Latency: done SHALL assert DATA_W+1 clocks after the edge that sampled start (15 clocks at default).
REQ-019 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 bin SHALL be sampled only at the accepting edge; later changes SHALL not affect the result.
REQ-022 num1..num4 SHALL hold their previous values throughout a conversion and change only in DONE.
REQ-023 start held high continuously SHALL start a new conversion on the first IDLE cycle after each DONE.
REQ-024 The accumulator SHALL carry a fifth (ten-thousands) nibble so inputs up to 2^DATA_W-1 convert without corruption of lower digits.

Reset
REQ-025 Reset assertion SHALL force IDLE, busy=0, done=0, num1..num4=4'h0, and clear the shift register, accumulator and counter, including mid-conversion (the conversion is aborted, not resumed).
REQ-026 The first start after reset release SHALL be accepted normally.

Configuration
REQ-027 Macro BCD_OVERFLOW_EN SHALL select overflow handling.
REQ-028 With BCD_OVERFLOW_EN defined: an input >= 10000 SHALL produce num1..num4 = 4'hE each, and an extra output ovf (1 bit) SHALL be registered high in DONE for that result and low for in-range results; ovf SHALL reset to 0.
REQ-029 Without BCD_OVERFLOW_EN: the ovf port SHALL not exist, and the ten-thousands digit SHALL be discarded, so the output equals bin mod 10000.

Verification
REQ-030 Reset, then start with bin=1234 -> done exactly 15 clocks later; num1..num4=1,2,3,4; busy high for 15 cycles.
REQ-031 bin=9999, then bin=0 -> digits 9,9,9,9 then 0,0,0,0; bin=5 -> 0,0,0,5 (add-3 boundary).
REQ-032 Second start issued 5 clocks into a conversion of 0042 -> ignored; a single done; digits 0,0,4,2.
REQ-033 Reset asserted at SHIFT cycle 7 of bin=8765 -> outputs 0, busy 0 immediately; no done pulse; next start with 0321 -> 0,3,2,1.
REQ-034 bin=12345 -> with macro: E,E,E,E and ovf=1; without macro: 2,3,4,5.
REQ-035 bin changed on the cycle after the start edge -> result reflects the sampled value.
